seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 20 ++
 rtl/seq_alu_addsub.sv | 23 ++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADDC = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_addsub.sv
// WIDTH-bit adder with carry-out and signed overflow; used for ADD/SUB and MUL accumulation.
module seq_alu_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH:0] w_full;
    logic           w_c_msb;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_cout  = w_full[WIDTH];
    // Carry into the MSB recovered from the MSB sum bit.
    assign w_c_msb = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ o_sum[WIDTH-1];
    assign o_ovf   = w_c_msb ^ o_cout;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; define SEQ_ALU_MUL_EN to build the
// iterative shift-add multiplier (opcode 1001) and its EXEC state.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_cout;
    logic             w_add_ovf;

    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;

`ifdef SEQ_ALU_MUL_EN
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] r_b;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    // Partial product lives in {r_result_hi, r_result}; multiplier bits shift out of r_result.
    assign w_step_hi = {w_add_cout, w_add_sum[WIDTH-1:1]};
    assign w_step_lo = {w_add_sum[0], r_result[WIDTH-1:1]};
`endif

    always_comb begin
        w_add_a   = i_a;
        w_add_b   = i_b;
        w_add_cin = 1'b0;
        if (i_opcode == OP_ADDC) begin
            w_add_cin = i_cin;
        end else if (i_opcode == OP_SUB) begin
            // a + (~b + 1) + cin: the +1 rides on the adder carry-in.
            w_add_b   = ~i_b + {{(WIDTH-1){1'b0}}, i_cin};
            w_add_cin = 1'b1;
        end
`ifdef SEQ_ALU_MUL_EN
        if (r_state == StExec) begin
            w_add_a   = r_result_hi;
            w_add_b   = r_result[0] ? r_b : '0;
            w_add_cin = 1'b0;
        end
`endif
    end

    seq_alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout),
        .o_ovf  (w_add_ovf)
    );

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (i_opcode)
            OP_ADDC, OP_ADD: begin
                w_res  = w_add_sum;
                w_cout = w_add_cout;
                w_ovf  = w_add_ovf;
            end
            OP_SUB: begin
                w_res  = w_add_sum;
                // b==0 with cin=1 wraps ~b+cin to zero and loses that carry.
                w_cout = w_add_cout | ((i_b == '0) & i_cin);
                w_ovf  = w_add_ovf;
            end
            OP_NAND: w_res = ~(i_a & i_b);
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_NOT:  w_res = ~i_a;
            OP_LSR: begin
                w_res  = {1'b0, i_a[WIDTH-1:1]};
                w_cout = i_a[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_result    <= '0;
            r_result_hi <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_b         <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                        if (i_opcode == OP_MUL) begin
                            r_state     <= StExec;
                            r_result    <= i_a;
                            r_result_hi <= '0;
                            r_b         <= i_b;
                            r_cnt       <= '0;
                            r_cout      <= 1'b0;
                            r_ovf       <= 1'b0;
                            r_zero      <= 1'b0;
                            r_neg       <= 1'b0;
                        end else
`endif
                        begin
                            r_state     <= StDone;
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_cout      <= w_cout;
                            r_ovf       <= w_ovf;
                            r_zero      <= (w_res == '0);
                            r_neg       <= w_res[WIDTH-1];
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                StExec: begin
                    r_result    <= w_step_lo;
                    r_result_hi <= w_step_hi;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        r_state <= StDone;
                        r_cout  <= (w_step_hi != '0);
                        r_zero  <= (w_step_lo == '0);
                        r_neg   <= w_step_lo[WIDTH-1];
                    end
                end
`endif
                StDone: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with an arithmetic reference model; MUL
// expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] e_res;
    logic [W-1:0] e_hi;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
    logic         e_neg;
    int           e_lat;
    bit           exp_ok = 1'b0;

    logic [W-1:0] c_res;
    logic [W-1:0] c_hi;
    logic         c_cout;
    logic         c_ovf;
    logic         c_zero;

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_opcode    (opcode),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_result_hi (result_hi),
        .o_cout      (cout),
        .o_ovf       (ovf),
        .o_zero      (zero),
        .o_neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint x);
        if (x >= (longint'(1) << (W - 1))) return x - (longint'(1) << W);
        return x;
    endfunction

    // Reference: plain integer arithmetic over the operation definitions.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] ia,
                                  input logic [W-1:0] ib, input logic ic);
        longint m = (longint'(1) << W) - 1;
        longint x = longint'(ia);
        longint y = longint'(ib);
        longint c = longint'(ic);
        longint t = 0;
        longint s = 0;
        longint hi = 0;
        bit arith = 1'b0;
        e_cout = 1'b0;
        e_ovf  = 1'b0;
        e_lat  = 1;
        case (op)
            4'd1: begin t = x + y + c; s = sx(x) + sx(y) + c; arith = 1'b1; end
            4'd2: begin t = x + y; s = sx(x) + sx(y); arith = 1'b1; end
            4'd3: begin t = x + ((~y) & m) + 1 + c; s = sx(x) - sx(y) + c; arith = 1'b1; end
            4'd4: t = (~(x & y)) & m;
            4'd5: t = x | y;
            4'd6: t = x ^ y;
            4'd7: t = (~x) & m;
            4'd8: begin t = x >> 1; e_cout = ia[0]; end
`ifdef SEQ_ALU_MUL_EN
            4'd9: begin t = x * y; hi = t >> W; e_cout = (hi != 0); e_lat = W + 1; end
`endif
            default: t = 0;
        endcase
        e_res = W'(t & m);
        e_hi  = W'(hi);
        if (arith) begin
            e_cout = ((t >> W) != 0);
            e_ovf  = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
        end
        e_zero = (e_res == '0);
        e_neg  = e_res[W-1];
    endfunction

    always @(negedge clk) begin
        if (exp_ok && out_valid) begin
            chk("result", result, e_res);
            chk("result_hi", result_hi, e_hi);
            chk("cout", cout, e_cout);
            chk("ovf", ovf, e_ovf);
            chk("zero", zero, e_zero);
            chk("neg", neg, e_neg);
        end
    end

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] ia,
                            input logic [W-1:0] ib, input logic ic);
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = ia;
        b        = ib;
        cin      = ic;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 4'($urandom);
        cin      = 1'($urandom);
        model(op, ia, ib, ic);
        exp_ok = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic ic, input int hold);
        int lat;
        start_op(op, ia, ib, ic);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            chk("busy_in_ready", in_ready, 0);
            in_valid = 1'($urandom);
            opcode   = 4'($urandom);
            a        = W'($urandom);
            if (lat > 2 * W + 4) begin
                chk("out_valid_timeout", 1, 0);
                in_valid = 1'b0;
                exp_ok   = 1'b0;
                return;
            end
        end
        chk("latency", lat, e_lat);
        c_res  = result;
        c_hi   = result_hi;
        c_cout = cout;
        c_ovf  = ovf;
        c_zero = zero;
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'($urandom);
            opcode    = 4'($urandom);
            a         = W'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
        end
        // A request offered on the release edge must not be taken.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_ok    = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'd0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", {result_hi, result}, 0);
        chk("rst_flags", {cout, ovf, zero, neg}, 0);

        do_op(4'b0001, 8'h7F, 8'h01, 1'b0, 0);
        chk("lit_add_res", c_res, 8'h80);
        chk("lit_add_ovf", {c_cout, c_ovf, c_zero}, 3'b010);

        do_op(4'b0010, 8'hFF, 8'h01, 1'b1, 1);
        do_op(4'b0001, 8'hFF, 8'h00, 1'b1, 0);
        do_op(4'b0011, 8'h05, 8'h03, 1'b0, 0);
        chk("lit_sub_res", c_res, 8'h02);
        chk("lit_sub_cout", {c_cout, c_ovf}, 2'b10);
        do_op(4'b0011, 8'h00, 8'h00, 1'b0, 0);
        chk("lit_sub0", {c_res, c_zero, c_cout}, {8'h00, 2'b11});
        do_op(4'b0011, 8'h80, 8'h01, 1'b0, 0);
        do_op(4'b0011, 8'h05, 8'h03, 1'b1, 0);
        do_op(4'b0100, 8'hF0, 8'h3C, 1'b1, 0);
        do_op(4'b0101, 8'hA0, 8'h05, 1'b0, 0);
        do_op(4'b0110, 8'hFF, 8'h0F, 1'b0, 2);
        do_op(4'b0111, 8'h5A, 8'h00, 1'b1, 0);

        do_op(4'b1000, 8'h81, 8'h00, 1'b0, 5);
        chk("lit_lsr", {c_res, c_cout}, {8'h40, 1'b1});

        do_op(4'b0000, 8'h12, 8'h34, 1'b1, 0);
        chk("lit_op0", {c_res, c_zero}, {8'h00, 1'b1});
        do_op(4'b1111, 8'hAB, 8'hCD, 1'b1, 0);

        do_op(4'b1001, 8'hFF, 8'hFF, 1'b0, 1);
`ifdef SEQ_ALU_MUL_EN
        chk("lit_mul", {c_hi, c_res, c_cout}, {8'hFE, 8'h01, 1'b1});
        do_op(4'b1001, 8'h0D, 8'h0B, 1'b0, 0);
        do_op(4'b1001, 8'h00, 8'h37, 1'b0, 0);
`else
        chk("lit_mul_off", {c_hi, c_res, c_zero}, {8'h00, 8'h00, 1'b1});
`endif

        // Reset three cycles into an operation, with a request offered on the reset edge.
`ifdef SEQ_ALU_MUL_EN
        start_op(4'b1001, 8'hFF, 8'hFF, 1'b0);
`else
        start_op(4'b1000, 8'h81, 8'h00, 1'b0);
`endif
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        opcode   = 4'b0010;
        a        = 8'h09;
        b        = 8'h09;
        @(posedge clk);
        #1;
        exp_ok   = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", {result_hi, result}, 0);
        chk("midrst_flags", {cout, ovf, zero, neg}, 0);

        do_op(4'b0010, 8'h02, 8'h03, 1'b0, 1);
        chk("lit_add_after_rst", c_res, 8'h05);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
